// File: rtl/fixed_to_float_seq.sv
// Multi-cycle fixed-point to IEEE-754 single converter with a binary-step
// leading-zero normaliser, optional round-to-nearest-even and valid/ready handshakes.
module fixed_to_float_seq #(
    parameter int WIDTH = 18,
    parameter int FRAC  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_signed,
    input  logic             round_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_inexact
);

    localparam int STEPS = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic             r_sign;
    logic             r_round;
    logic             r_zero;
    logic [WIDTH-1:0] r_mag;
    logic [3:0]       r_step;
    logic [5:0]       r_lz;
    logic [31:0]      r_out_data;
    logic             r_inexact;

    logic             w_in_neg;
    logic [WIDTH-1:0] w_in_mag;
    logic             w_last_step;
    int unsigned      w_shift_amt;
    logic             w_top_zero;
    logic [WIDTH-1:0] w_mag_shl;
    logic [63:0]      w_al;
    logic [22:0]      w_frac;
    logic             w_guard;
    logic             w_sticky;
    logic             w_inc;
    logic [23:0]      w_frac_rnd;
    logic [7:0]       w_exp;
    logic [7:0]       w_exp_f;

    assign w_in_neg = in_signed & in_data[WIDTH-1];
    assign w_in_mag = w_in_neg ? -in_data : in_data;

    // Step k tests the top 2^(STEPS-1-k) bits and shifts them out when all zero.
    assign w_last_step = (r_step == 4'(STEPS - 1));
    assign w_shift_amt = 32'd1 << (STEPS - 1 - int'(r_step));
    assign w_top_zero  = ((r_mag >> (WIDTH - w_shift_amt)) == '0);
    assign w_mag_shl   = r_mag << w_shift_amt;

    // Drop the leading one and left-align the remainder at bit 63.
    assign w_al       = 64'(r_mag) << (65 - WIDTH);
    assign w_frac     = w_al[63:41];
    assign w_guard    = w_al[40];
    assign w_sticky   = |w_al[39:0];
    assign w_inc      = r_round & w_guard & (w_sticky | w_frac[0]);
    assign w_frac_rnd = {1'b0, w_frac} + {23'd0, w_inc};
    assign w_exp      = 8'(127 + WIDTH - 1 - FRAC) - {2'b00, r_lz};
    assign w_exp_f    = w_exp + {7'd0, w_frac_rnd[23]};

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)    w_next = S_NORM;
            S_NORM:  if (w_last_step) w_next = S_ROUND;
            S_ROUND: w_next = S_DONE;
            S_DONE:  if (out_ready)   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sign     <= 1'b0;
            r_round    <= 1'b0;
            r_zero     <= 1'b0;
            r_mag      <= '0;
            r_step     <= '0;
            r_lz       <= '0;
            r_out_data <= '0;
            r_inexact  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign  <= w_in_neg;
                        r_mag   <= w_in_mag;
                        r_zero  <= (w_in_mag == '0);
                        r_round <= round_en;
                        r_step  <= '0;
                        r_lz    <= '0;
                    end
                end
                S_NORM: begin
                    if (w_top_zero) begin
                        r_mag <= w_mag_shl;
                        r_lz  <= r_lz + 6'(w_shift_amt);
                    end
                    if (!w_last_step) r_step <= r_step + 4'd1;
                end
                S_ROUND: begin
                    if (r_zero) begin
                        r_out_data <= '0;
                        r_inexact  <= 1'b0;
                    end else begin
                        r_out_data <= {r_sign, w_exp_f, w_frac_rnd[22:0]};
                        r_inexact  <= w_guard | w_sticky;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign out_data    = r_out_data;
    assign out_inexact = r_inexact;

endmodule

// File: doc/fixed_to_float_seq.md
# fixed_to_float_seq

Parametrised, multi-cycle successor to the combinational Q2.16-to-float converter. It converts a WIDTH-bit fixed-point value with FRAC fraction bits, signed or unsigned per transaction, to IEEE-754 single precision. It uses an iterative binary-step normaliser, optional round-to-nearest-even, an inexact flag, and valid/ready handshakes on both sides. It sits between the CORDIC datapath and the peripheral read register, and is reusable for any fixed-point result that needs float output.

## Interface
Parameters:
- WIDTH, 18: input width, legal 2..32.
- FRAC, 16: fraction bits, legal 0..WIDTH.
- Derived: STEPS = clog2(WIDTH), the number of normalise cycles.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept a word; high only in IDLE.
- in_data  in  WIDTH  fixed-point operand.
- in_signed  in  1  1 = two's complement, 0 = unsigned; sampled at accept.
- round_en  in  1  1 = round-to-nearest-even, 0 = truncate; sampled at accept.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- out_data  out  32  IEEE-754 single result.
- out_inexact  out  1  discarded mantissa bits were non-zero.

## Operation
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE → NORM on in_valid & in_ready (the accept edge). At accept, latch:
  - sign = in_signed & in_data[WIDTH-1];
  - mag = sign ? -in_data : in_data, as unsigned WIDTH bits (the most negative value gives 2^(WIDTH-1));
  - round mode;
  - zero flag = (mag == 0);
  - step counter = 0; lz = 0.
- NORM runs for exactly STEPS cycles. Step k uses s = 2^(STEPS-1-k). If the top s bits of mag are all zero, then mag <<= s and lz += s. After the last step, go to ROUND.
- ROUND, for a non-zero input:
  - exp = 127 + (WIDTH-1-lz) - FRAC.
  - frac = mag[WIDTH-2:0] left-aligned into 23 bits. If WIDTH-1 ≤ 23, pad with zeros and set inexact = 0.
  - If WIDTH-1 > 23: guard = the bit below frac LSB, sticky = OR of the remaining bits, inexact = guard | sticky.
  - If round_en and guard & (sticky | frac[0]): frac += 1. On carry-out, frac = 0 and exp += 1.
  - Register out_data = {sign, exp[7:0], frac}. Go to DONE.
- Zero input: out_data = 32'h0000_0000 (+0 also for the negative path), out_inexact = 0. It takes the same cycle count as non-zero input.
- DONE: out_valid = 1. out_data and out_inexact are stable until out_valid & out_ready, then → IDLE.
- Only one transaction is in flight. in_ready = 0 in NORM, ROUND and DONE.
- Legal parameters cannot overflow or underflow the exponent; no inf/NaN/denormal is ever produced.

## Timing
- Reset values (sync, rst_n low at an edge): state IDLE, out_valid 0, out_data 0, out_inexact 0, internal regs 0. in_ready is 1 from the first cycle with rst_n high.
- Reset in any state abandons the transaction. out_valid is 0 after that edge and no result is emitted.
- Latency: out_valid rises STEPS+1 edges after the accept edge (6 for WIDTH=18). This is independent of data and mode.
- Throughput: with out_ready held high, one result per STEPS+3 cycles. DONE→IDLE takes one edge; the next accept is on the following edge.
- in_valid asserted outside IDLE is ignored. in_data, in_signed and round_en are don't-care except on the accept edge.
- out_ready is ignored while out_valid = 0.

## Test plan
- WIDTH=18, FRAC=16, signed:
  - in 0x10000 → out 0x3F800000, inexact 0, out_valid exactly 6 edges after accept.
  - in 0x20000 → 0xC0000000.
  - same in 0x20000 with in_signed=0 → 0x40000000.
  - in 0x00001 → 0x37800000.
  - in 0 → 0x00000000.
- WIDTH=32, FRAC=0, unsigned:
  - 0x01000001 → 0x4B800000, inexact 1, in both modes (tie, LSB even).
  - 0x01000003 → RNE 0x4B800002, truncate 0x4B800001, inexact 1.
  - 0xFFFFFFFF, RNE → 0x4F800000 (mantissa carry, exp 159).
  - 0xFFFFFFFF, truncate → 0x4F7FFFFF.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_data/out_inexact stable, in_ready 0, and an in_valid pulse meanwhile is not accepted. Release out_ready → in_ready high one edge later.
- Reset mid-NORM (3 edges after accept) → next cycle out_valid 0, out_data 0, in_ready 1. A new 0x10000 then yields 0x3F800000 with the normal latency.
- Back-to-back stream of 100 random WIDTH=18 words, random in_signed/round_en/out_ready stalls → every result matches the reference model (exact float of value × 2^-FRAC, RNE or truncated). No word is dropped or duplicated.
